// File: rtl/vld_rdy_fifo.sv
// Purpose : DEPTH-entry, DW-bit valid/ready buffering stage that reports its occupancy.
// Latency : a beat accepted at edge N appears on vld_o/dat_o after edge N; there is no dat_i->dat_o bypass.
// Backpr. : rdy_o = ~full (CUT_READY=1) or ~full | pop (CUT_READY=0); dat_o is held while vld_o & ~rdy_i.
// Option  : define VLD_RDY_FIFO_FLUSH_EN to add the synchronous flush_i port, which has priority over push/pop.
module vld_rdy_fifo #(
  parameter int DW        = 32,
  parameter int DEPTH     = 2,
  parameter int CUT_READY = 0,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vld_i,
  output logic          rdy_o,
  input  logic [DW-1:0] dat_i,
  output logic          vld_o,
  input  logic          rdy_i,
  output logic [DW-1:0] dat_o,
  output logic [CW-1:0] cnt_o
`ifdef VLD_RDY_FIFO_FLUSH_EN
  ,
  input  logic          flush_i
`endif
);

  // Pointers need at least one bit. With DEPTH=1 the memory is padded to two
  // entries so that the 1-bit pointer indexes it exactly; entry 1 is never written.
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MEM_N = (DEPTH > 1) ? DEPTH : 2;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] mem [MEM_N];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          flush;
  logic          full;
  logic          push;
  logic          pop;

`ifdef VLD_RDY_FIFO_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Wrap with an explicit compare so that a DEPTH that is not a power of two still cycles 0..DEPTH-1.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  assign full  = (cnt == FULL_CNT);
  // A flush cycle hides the head and refuses input, so no handshake can occur in that cycle.
  assign vld_o = (cnt != '0) & ~flush;
  assign pop   = vld_o & rdy_i;

  generate
    if (CUT_READY != 0) begin : g_cut_ready
      // Ready depends only on registered state, which breaks the rdy_i->rdy_o path.
      assign rdy_o = ~full & ~flush;
    end else begin : g_pass_ready
      // While full, a beat can still be accepted in the same cycle that the head leaves.
      assign rdy_o = (~full | pop) & ~flush;
    end
  endgenerate

  assign push  = vld_i & rdy_o;
  assign dat_o = mem[rd_ptr];
  assign cnt_o = cnt;

  // Pointer and occupancy bookkeeping. Flush returns both to empty, and simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (push && !pop) begin
        cnt <= cnt + CW'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Payload storage. Reset clears every entry so that dat_o reads 0 out of reset. Flush leaves entries stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_N; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= dat_i;
    end
  end

endmodule
